// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 2-bit port, 4-bit length, D data bits, idle gap.
// Define PARITY_EN to insert an even-parity bit after non-empty payloads.
module serial_frame_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        clkEn,
    input  logic        start,
    input  logic [1:0]  port,
    input  logic [3:0]  len,
    input  logic [14:0] data,
    output logic        ready,
    output logic        SerOut,
    output logic        Done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        LEN   = 3'd3,
        DATA  = 3'd4,
`ifdef PARITY_EN
        PAR   = 3'd5,
`endif
        GAP   = 3'd6
    } state_t;

    state_t      state;
    state_t      nstate;
    logic        ser;
    logic        nser;
    logic [3:0]  cnt;
    logic [3:0]  ncnt;
    logic [1:0]  port_q;
    logic [3:0]  len_q;
    logic [14:0] data_q;
    logic        accept;
    logic [3:0]  bit_idx;
    logic [3:0]  data_idx;
    logic [3:0]  len_idx;

    assign bit_idx  = cnt - 4'd1;
    assign data_idx = cnt - 4'd2;
    assign len_idx  = len_q - 4'd1;

`ifdef PARITY_EN
    logic [14:0] data_mask;
    logic        par_bit;

    assign data_mask = (15'd1 << len_q) - 15'd1;
    assign par_bit   = ^(data_q & data_mask);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ser    <= 1'b1;
            cnt    <= 4'd0;
            port_q <= 2'd0;
            len_q  <= 4'd0;
            data_q <= 15'd0;
        end else if (clkEn) begin
            state <= nstate;
            ser   <= nser;
            cnt   <= ncnt;
            if (accept) begin
                port_q <= port;
                len_q  <= len;
                data_q <= data;
            end
        end
    end

    // cnt holds the index of the bit on the line in ADDR/LEN, and the remaining
    // payload bits (including the one on the line) in DATA.
    always_comb begin
        nstate = state;
        nser   = ser;
        ncnt   = cnt;
        accept = 1'b0;
        case (state)
            IDLE: begin
                nser = 1'b1;
                if (start) begin
                    accept = 1'b1;
                    nstate = START;
                    nser   = 1'b0;
                    ncnt   = 4'd0;
                end
            end
            START: begin
                nstate = ADDR;
                nser   = port_q[1];
                ncnt   = 4'd1;
            end
            ADDR: begin
                if (cnt != 4'd0) begin
                    nser = port_q[bit_idx[0]];
                    ncnt = bit_idx;
                end else begin
                    nstate = LEN;
                    nser   = len_q[3];
                    ncnt   = 4'd3;
                end
            end
            LEN: begin
                if (cnt != 4'd0) begin
                    nser = len_q[bit_idx[1:0]];
                    ncnt = bit_idx;
                end else if (len_q == 4'd0) begin
                    nstate = GAP;
                    nser   = 1'b1;
                end else begin
                    nstate = DATA;
                    nser   = data_q[len_idx];
                    ncnt   = len_q;
                end
            end
            DATA: begin
                if (cnt > 4'd1) begin
                    nser = data_q[data_idx];
                    ncnt = bit_idx;
                end else begin
                    ncnt = 4'd0;
`ifdef PARITY_EN
                    nstate = PAR;
                    nser   = par_bit;
`else
                    nstate = GAP;
                    nser   = 1'b1;
`endif
                end
            end
`ifdef PARITY_EN
            PAR: begin
                nstate = GAP;
                nser   = 1'b1;
            end
`endif
            GAP: begin
                nstate = IDLE;
                nser   = 1'b1;
            end
            default: begin
                nstate = IDLE;
                nser   = 1'b1;
                ncnt   = 4'd0;
            end
        endcase
    end

    assign ready  = (state == IDLE);
    assign Done   = (state == GAP);
    assign SerOut = ser;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: frame bit patterns, bit-rate enable, ignored
// requests and mid-frame reset. Follows PARITY_EN when the design is built with it.
module tb_serial_frame_tx;

    logic        clk;
    logic        rst;
    logic        clkEn;
    logic        start;
    logic [1:0]  port;
    logic [3:0]  len;
    logic [14:0] data;
    logic        ready;
    logic        SerOut;
    logic        Done;

    int errors = 0;
    int checks = 0;

    serial_frame_tx dut (
        .clk    (clk),
        .rst    (rst),
        .clkEn  (clkEn),
        .start  (start),
        .port   (port),
        .len    (len),
        .data   (data),
        .ready  (ready),
        .SerOut (SerOut),
        .Done   (Done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Sends one frame and checks every clock of it against a hand-built bit list.
    // div: clkEn high once every div clocks. injectAt: period in which a new
    // request with different fields is presented. abortAt: period in which rst hits.
    task automatic applyStimulus(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d,
                                 input int div, input int injectAt, input int abortAt);
        logic expBits[$];
        logic par;
        int   n;
        par = 1'b0;
        expBits.push_back(1'b0);
        expBits.push_back(p[1]);
        expBits.push_back(p[0]);
        for (int b = 3; b >= 0; b--) expBits.push_back(l[b]);
        for (int b = int'(l) - 1; b >= 0; b--) begin
            expBits.push_back(d[b]);
            par ^= d[b];
        end
`ifdef PARITY_EN
        if (l != 4'd0) expBits.push_back(par);
`endif
        expBits.push_back(1'b1);
        n = expBits.size();

        port  = p;
        len   = l;
        data  = d;
        start = 1'b1;
        clkEn = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("accept ready", 16'(ready), 16'd0);

        for (int i = 0; i < n; i++) begin
            if (i == abortAt) begin
                rst = 1'b1;
                #1;
                checkOutput("abort ser", 16'(SerOut), 16'd1);
                checkOutput("abort ready", 16'(ready), 16'd1);
                checkOutput("abort done", 16'(Done), 16'd0);
                repeat (3) begin
                    @(posedge clk); #1;
                    checkOutput("abort no done", 16'(Done), 16'd0);
                end
                rst = 1'b0;
                clkEn = 1'b1;
                return;
            end
            for (int k = 0; k < div; k++) begin
                checkOutput($sformatf("ser p%0d c%0d", i, k), 16'(SerOut), 16'(expBits[i]));
                checkOutput($sformatf("done p%0d c%0d", i, k), 16'(Done), 16'(i == n - 1));
                clkEn = (k == div - 1);
                if (i == injectAt && k == div - 1) begin
                    start = 1'b1;
                    port  = ~p;
                    len   = 4'hF;
                    data  = ~d;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        clkEn = 1'b1;
        checkOutput("end ready", 16'(ready), 16'd1);
        checkOutput("end ser", 16'(SerOut), 16'd1);
        checkOutput("end done", 16'(Done), 16'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        clk   = 1'b0;
        rst   = 1'b1;
        clkEn = 1'b0;
        start = 1'b0;
        port  = 2'd0;
        len   = 4'd0;
        data  = 15'd0;
        #2;
        checkOutput("reset ready", 16'(ready), 16'd1);
        checkOutput("reset ser", 16'(SerOut), 16'd1);
        checkOutput("reset done", 16'(Done), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // A request without clkEn must not be taken.
        start = 1'b1;
        clkEn = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("no en ready", 16'(ready), 16'd1);
        checkOutput("no en ser", 16'(SerOut), 16'd1);
        start = 1'b0;
        clkEn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] frame port=2 len=3 data=101");
        applyStimulus(2'b10, 4'd3, 15'b101, 1, -1, -1);
        $display("[TB] frame port=1 len=0");
        applyStimulus(2'b01, 4'd0, 15'h1234, 1, -1, -1);
        $display("[TB] frame len=15 data=7FFF with clkEn 1 in 4");
        applyStimulus(2'b11, 4'd15, 15'h7FFF, 4, -1, -1);
        $display("[TB] frame with request presented during DATA");
        applyStimulus(2'b10, 4'd3, 15'b101, 1, 8, -1);
        $display("[TB] frame aborted by reset in DATA");
        applyStimulus(2'b10, 4'd3, 15'b101, 1, -1, 9);
        $display("[TB] frame after abort");
        applyStimulus(2'b01, 4'd6, 15'b110010, 1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
